t06_snake_body_tracker: RTL and testbench

//  Upstream stage of the image generator. Owns the snake's segment coordinates on the 16x16 grid.

---
 rtl/t06_snake_body_tracker.sv | 114 +++++++++++
 tb/tb_t06_snake_body_tracker.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/t06_snake_body_tracker.sv
// Snake segment store for the 16x16 playfield: moves, grows, detects wall/self hits
// and answers per-pixel head/body/border queries for the image generator.
module t06_snake_body_tracker #(
    parameter int MAX_LEN = 50,
    parameter int START_X = 4,
    parameter int START_Y = 7,
    parameter int LW      = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          step,
    input  logic [1:0]    dir,
    input  logic          grow,
    input  logic [3:0]    x,
    input  logic [3:0]    y,
    output logic          snakeHead,
    output logic          snakeBody,
    output logic          border,
    output logic [3:0]    head_x,
    output logic [3:0]    head_y,
    output logic [LW-1:0] len,
    output logic          GameOver
);

    typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;

    state_t        state, next_state;
    logic [3:0]    seg_x [MAX_LEN];
    logic [3:0]    seg_y [MAX_LEN];
    logic [LW-1:0] len_r;
    logic [1:0]    cur_dir;

    logic [1:0]    nd;
    logic [3:0]    nh_x, nh_y;
    logic          eff_grow, hit_wall, hit_self, do_move;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-head computation and collision tests; the tail is exempt only when it vacates.
    always_comb begin
        next_state = state;
        do_move    = 1'b0;
        nd         = (dir == (cur_dir ^ 2'b01)) ? cur_dir : dir;
        nh_x       = seg_x[0];
        nh_y       = seg_y[0];
        case (nd)
            2'd0:    nh_x = seg_x[0] + 4'd1;
            2'd1:    nh_x = seg_x[0] - 4'd1;
            2'd2:    nh_y = seg_y[0] - 4'd1;
            default: nh_y = seg_y[0] + 4'd1;
        endcase
        hit_wall = (nh_x == 4'd0) || (nh_x == 4'd15) || (nh_y == 4'd0) || (nh_y == 4'd15);
        eff_grow = grow && (len_r < LW'(MAX_LEN));
        hit_self = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if ((LW'(i) < len_r) && (eff_grow || (LW'(i) != len_r - LW'(1))) &&
                (seg_x[i] == nh_x) && (seg_y[i] == nh_y))
                hit_self = 1'b1;
        end
        case (state)
            IDLE: if (start) next_state = RUN;
            RUN: begin
                if (step) begin
                    if (hit_wall || hit_self) next_state = DEAD;
                    else                      do_move    = 1'b1;
                end
            end
            default: next_state = DEAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_x[0] <= 4'(START_X);
            seg_y[0] <= 4'(START_Y);
            seg_x[1] <= 4'(START_X - 1);
            seg_y[1] <= 4'(START_Y);
            len_r    <= LW'(2);
            cur_dir  <= 2'd0;
        end else begin
            if (state == RUN && step) cur_dir <= nd;
            if (do_move) begin
                for (int i = MAX_LEN - 1; i >= 1; i--) begin
                    seg_x[i] <= seg_x[i-1];
                    seg_y[i] <= seg_y[i-1];
                end
                seg_x[0] <= nh_x;
                seg_y[0] <= nh_y;
                if (eff_grow) len_r <= len_r + LW'(1);
            end
        end
    end

    // Pixel query: only live segments are ever reported.
    always_comb begin
        snakeHead = (x == seg_x[0]) && (y == seg_y[0]);
        snakeBody = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if ((LW'(i) < len_r) && (x == seg_x[i]) && (y == seg_y[i]))
                snakeBody = 1'b1;
        end
        border = (x == 4'd0) || (x == 4'd15) || (y == 4'd0) || (y == 4'd15);
    end

    assign head_x   = seg_x[0];
    assign head_y   = seg_y[0];
    assign len      = len_r;
    assign GameOver = (state == DEAD);

endmodule

// File: tb/tb_t06_snake_body_tracker.sv
// Testbench for t06_snake_body_tracker: directed scenarios plus randomized play
// checked against a queue-based snake model.
module tb_t06_snake_body_tracker;

    logic       clk = 1'b0;
    logic       rst = 1'b0, start = 1'b0, step = 1'b0, grow = 1'b0;
    logic [1:0] dir = 2'd0;
    logic [3:0] x = 4'd0, y = 4'd0;
    logic       snakeHead, snakeBody, border, GameOver;
    logic [3:0] head_x, head_y;
    logic [5:0] len;

    int checks = 0;
    int errors = 0;

    // Reference model: snake as a queue of cells, head at the front.
    int qx[$];
    int qy[$];
    int mdir;
    int mstate;  // 0 idle, 1 running, 2 dead

    t06_snake_body_tracker dut (
        .clk(clk), .rst(rst), .start(start), .step(step), .dir(dir), .grow(grow),
        .x(x), .y(y), .snakeHead(snakeHead), .snakeBody(snakeBody), .border(border),
        .head_x(head_x), .head_y(head_y), .len(len), .GameOver(GameOver)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        qx = {4, 3};
        qy = {7, 7};
        mdir = 0;
        mstate = 0;
    endfunction

    function automatic void model_cycle(input bit st, input bit s, input int d, input bit g);
        int nd, nx, ny, last;
        bit eg, dead;
        if (mstate == 0) begin
            if (st) mstate = 1;
        end else if (mstate == 1 && s) begin
            nd = (d == (mdir ^ 1)) ? mdir : d;
            mdir = nd;
            nx = qx[0] + (nd == 0) - (nd == 1);
            ny = qy[0] + (nd == 3) - (nd == 2);
            eg = g && (qx.size() < 50);
            dead = (nx == 0) || (nx == 15) || (ny == 0) || (ny == 15);
            last = qx.size() - 1;
            for (int i = 1; i <= last; i++)
                if (!(i == last && !eg) && qx[i] == nx && qy[i] == ny) dead = 1;
            if (dead) mstate = 2;
            else begin
                qx.push_front(nx);
                qy.push_front(ny);
                if (!eg) begin
                    void'(qx.pop_back());
                    void'(qy.pop_back());
                end
            end
        end
    endfunction

    function automatic logic [14:0] model_state();
        return {4'(qx[0]), 4'(qy[0]), 6'(qx.size()), mstate == 2};
    endfunction

    function automatic logic [2:0] model_query(input int qxv, input int qyv);
        bit h, b, br;
        h = (qx[0] == qxv) && (qy[0] == qyv);
        b = 0;
        for (int i = 1; i < qx.size(); i++)
            if (qx[i] == qxv && qy[i] == qyv) b = 1;
        br = (qxv == 0) || (qxv == 15) || (qyv == 0) || (qyv == 15);
        return {h, b, br};
    endfunction

    task automatic do_cycle(input bit st, input bit s, input int d, input bit g);
        start = st; step = s; dir = 2'(d); grow = g;
        @(posedge clk);
        #1;
        start = 0; step = 0; grow = 0;
        model_cycle(st, s, d, g);
    endtask

    task automatic do_reset();
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({head_x, head_y, len, GameOver} !== {4'd4, 4'd7, 6'd2, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_state got %h exp %h", {head_x, head_y, len, GameOver}, {4'd4, 4'd7, 6'd2, 1'b0});
        end
        x = 4'd3; y = 4'd7; #1;
        checks++;
        if ({snakeHead, snakeBody, border} !== 3'b010) begin
            errors++;
            $display("[TB] FAIL reset_tail_query got %b exp 010", {snakeHead, snakeBody, border});
        end
        do_cycle(0, 1, 0, 1);
        checks++;
        if ({head_x, head_y, len} !== {4'd4, 4'd7, 6'd2}) begin
            errors++;
            $display("[TB] FAIL idle_step_ignored got %h exp %h", {head_x, head_y, len}, {4'd4, 4'd7, 6'd2});
        end
    endtask

    task automatic test_move_and_reverse();
        do_reset();
        do_cycle(1, 0, 0, 0);
        repeat (3) do_cycle(0, 1, 0, 0);
        checks++;
        if ({head_x, head_y, len, GameOver} !== {4'd7, 4'd7, 6'd2, 1'b0}) begin
            errors++;
            $display("[TB] FAIL move3_state got %h exp %h", {head_x, head_y, len, GameOver}, {4'd7, 4'd7, 6'd2, 1'b0});
        end
        x = 4'd6; y = 4'd7; #1;
        checks++;
        if ({snakeHead, snakeBody} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL move3_tail_query got %b exp 01", {snakeHead, snakeBody});
        end
        x = 4'd5; #1;
        checks++;
        if (snakeBody !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stale_segment_query got %b exp 0", snakeBody);
        end
        do_cycle(0, 1, 1, 0);
        checks++;
        if ({head_x, head_y} !== {4'd8, 4'd7}) begin
            errors++;
            $display("[TB] FAIL reverse_ignored got %h exp %h", {head_x, head_y}, {4'd8, 4'd7});
        end
        do_cycle(0, 1, 1, 0);
        checks++;
        if ({head_x, head_y} !== {4'd9, 4'd7}) begin
            errors++;
            $display("[TB] FAIL dir_kept_right got %h exp %h", {head_x, head_y}, {4'd9, 4'd7});
        end
        do_cycle(0, 0, 3, 1);
        checks++;
        if ({head_x, head_y, len} !== {4'd9, 4'd7, 6'd2}) begin
            errors++;
            $display("[TB] FAIL no_step_hold got %h exp %h", {head_x, head_y, len}, {4'd9, 4'd7, 6'd2});
        end
    endtask

    task automatic test_growth();
        int d;
        do_reset();
        do_cycle(1, 0, 0, 0);
        repeat (3) do_cycle(0, 1, 0, 1);
        checks++;
        if (len !== 6'd5) begin
            errors++;
            $display("[TB] FAIL grow3_len got %0d exp 5", len);
        end
        // Serpentine through rows 7 and below so growth never self-collides.
        for (int n = 0; n < 48; n++) begin
            if (((qy[0] - 7) % 2) == 0) d = (qx[0] < 14) ? 0 : 3;
            else                        d = (qx[0] > 1) ? 1 : 3;
            do_cycle(0, 1, d, qx.size() < 50);
            checks++;
            if ({head_x, head_y, len, GameOver} !== model_state()) begin
                errors++;
                $display("[TB] FAIL serpentine_state got %h exp %h", {head_x, head_y, len, GameOver}, model_state());
            end
        end
        checks++;
        if (len !== 6'd50) begin
            errors++;
            $display("[TB] FAIL max_len got %0d exp 50", len);
        end
        for (int n = 0; n < 3; n++) begin
            if (((qy[0] - 7) % 2) == 0) d = (qx[0] < 14) ? 0 : 3;
            else                        d = (qx[0] > 1) ? 1 : 3;
            do_cycle(0, 1, d, 1);
            checks++;
            if ({head_x, head_y, len, GameOver} !== model_state() || len !== 6'd50) begin
                errors++;
                $display("[TB] FAIL saturate_grow got %h exp %h", {head_x, head_y, len, GameOver}, model_state());
            end
        end
    endtask

    task automatic test_wall();
        do_reset();
        do_cycle(1, 0, 0, 0);
        repeat (10) do_cycle(0, 1, 0, 0);
        checks++;
        if ({head_x, head_y, GameOver} !== {4'd14, 4'd7, 1'b0}) begin
            errors++;
            $display("[TB] FAIL wall_approach got %h exp %h", {head_x, head_y, GameOver}, {4'd14, 4'd7, 1'b0});
        end
        do_cycle(0, 1, 0, 0);
        checks++;
        if ({head_x, head_y, len, GameOver} !== {4'd14, 4'd7, 6'd2, 1'b1}) begin
            errors++;
            $display("[TB] FAIL wall_hit got %h exp %h", {head_x, head_y, len, GameOver}, {4'd14, 4'd7, 6'd2, 1'b1});
        end
        do_cycle(1, 1, 3, 1);
        do_cycle(0, 1, 2, 0);
        checks++;
        if ({head_x, head_y, len, GameOver} !== {4'd14, 4'd7, 6'd2, 1'b1}) begin
            errors++;
            $display("[TB] FAIL dead_frozen got %h exp %h", {head_x, head_y, len, GameOver}, {4'd14, 4'd7, 6'd2, 1'b1});
        end
        x = 4'd13; y = 4'd7; #1;
        checks++;
        if ({snakeHead, snakeBody, border} !== 3'b010) begin
            errors++;
            $display("[TB] FAIL dead_query got %b exp 010", {snakeHead, snakeBody, border});
        end
        x = 4'd15; #1;
        checks++;
        if ({snakeHead, snakeBody, border} !== 3'b001) begin
            errors++;
            $display("[TB] FAIL border_query got %b exp 001", {snakeHead, snakeBody, border});
        end
    endtask

    task automatic setup_square();
        do_reset();
        do_cycle(1, 0, 0, 0);
        do_cycle(0, 1, 0, 1);
        do_cycle(0, 1, 3, 1);
        do_cycle(0, 1, 1, 0);
    endtask

    task automatic test_tail_chase();
        setup_square();
        checks++;
        if ({head_x, head_y, len, GameOver} !== {4'd4, 4'd8, 6'd4, 1'b0}) begin
            errors++;
            $display("[TB] FAIL square_setup got %h exp %h", {head_x, head_y, len, GameOver}, {4'd4, 4'd8, 6'd4, 1'b0});
        end
        do_cycle(0, 1, 2, 0);
        do_cycle(0, 1, 0, 0);
        checks++;
        if ({head_x, head_y, len, GameOver} !== {4'd5, 4'd7, 6'd4, 1'b0}) begin
            errors++;
            $display("[TB] FAIL tail_chase_ok got %h exp %h", {head_x, head_y, len, GameOver}, {4'd5, 4'd7, 6'd4, 1'b0});
        end
        setup_square();
        do_cycle(0, 1, 2, 1);
        checks++;
        if ({head_x, head_y, len, GameOver} !== {4'd4, 4'd8, 6'd4, 1'b1}) begin
            errors++;
            $display("[TB] FAIL tail_chase_grow got %h exp %h", {head_x, head_y, len, GameOver}, {4'd4, 4'd8, 6'd4, 1'b1});
        end
    endtask

    task automatic test_reset_during_step();
        do_reset();
        do_cycle(1, 0, 0, 0);
        do_cycle(0, 1, 3, 1);
        rst = 1; step = 1; dir = 2'd3; grow = 1;
        @(posedge clk);
        #1;
        rst = 0; step = 0; grow = 0;
        model_reset();
        checks++;
        if ({head_x, head_y, len, GameOver} !== {4'd4, 4'd7, 6'd2, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_wins got %h exp %h", {head_x, head_y, len, GameOver}, {4'd4, 4'd7, 6'd2, 1'b0});
        end
        do_cycle(0, 1, 0, 0);
        checks++;
        if ({head_x, head_y} !== {4'd4, 4'd7}) begin
            errors++;
            $display("[TB] FAIL reset_to_idle got %h exp %h", {head_x, head_y}, {4'd4, 4'd7});
        end
    endtask

    task automatic test_random();
        int qxv, qyv, after_dead;
        for (int ep = 0; ep < 25; ep++) begin
            do_reset();
            do_cycle(1, 0, 0, 0);
            after_dead = 0;
            for (int c = 0; c < 150 && after_dead < 4; c++) begin
                do_cycle($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
                         int'($urandom_range(0, 3)), $urandom_range(0, 3) == 0);
                if (mstate == 2) after_dead++;
                checks++;
                if ({head_x, head_y, len, GameOver} !== model_state()) begin
                    errors++;
                    $display("[TB] FAIL random_state got %h exp %h", {head_x, head_y, len, GameOver}, model_state());
                end
                if ($urandom_range(0, 1) == 0) begin
                    qxv = qx[$urandom_range(0, qx.size() - 1)];
                    qyv = qy[$urandom_range(0, qy.size() - 1)];
                end else begin
                    qxv = $urandom_range(0, 15);
                    qyv = $urandom_range(0, 15);
                end
                x = 4'(qxv); y = 4'(qyv); #1;
                checks++;
                if ({snakeHead, snakeBody, border} !== model_query(qxv, qyv)) begin
                    errors++;
                    $display("[TB] FAIL random_query (%0d,%0d) got %b exp %b", qxv, qyv,
                             {snakeHead, snakeBody, border}, model_query(qxv, qyv));
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_move_and_reverse();
        test_growth();
        test_wall();
        test_tail_chase();
        test_reset_during_step();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
